// File: rtl/axi_ram_bridge.sv
// AXI4 slave bridging single-beat-per-cycle writes and three-cycle reads onto a
// one-cycle-latency word RAM, with an optional read gate on FFT completion.
module axi_ram_bridge #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned READ_GATE  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [ADDR_WIDTH-1:0]      i_AWADDR,
  input  logic [7:0]                 i_AWLEN,
  input  logic [2:0]                 i_AWSIZE,
  input  logic [1:0]                 i_AWBURST,
  input  logic [ID_WIDTH-1:0]        i_AWID,
  input  logic                       i_AWVALID,
  output logic                       o_AWREADY,
  input  logic [DATA_WIDTH-1:0]      i_WDATA,
  input  logic [DATA_WIDTH/8-1:0]    i_WSTRB,
  input  logic                       i_WLAST,
  input  logic                       i_WVALID,
  output logic                       o_WREADY,
  output logic [ID_WIDTH-1:0]        o_BID,
  output logic [1:0]                 o_BRESP,
  output logic                       o_BVALID,
  input  logic                       i_BREADY,
  input  logic [ADDR_WIDTH-1:0]      i_ARADDR,
  input  logic [7:0]                 i_ARLEN,
  input  logic [2:0]                 i_ARSIZE,
  input  logic [1:0]                 i_ARBURST,
  input  logic [ID_WIDTH-1:0]        i_ARID,
  input  logic                       i_ARVALID,
  output logic                       o_ARREADY,
  output logic [DATA_WIDTH-1:0]      o_RDATA,
  output logic [ID_WIDTH-1:0]        o_RID,
  output logic [1:0]                 o_RRESP,
  output logic                       o_RLAST,
  output logic                       o_RVALID,
  input  logic                       i_RREADY,
  output logic                       o_ram_we,
  output logic                       o_ram_re,
  output logic [$clog2(DEPTH)-1:0]   o_ram_index,
  output logic [DATA_WIDTH-1:0]      o_ram_wdata,
  output logic [DATA_WIDTH/8-1:0]    o_ram_be,
  input  logic [DATA_WIDTH-1:0]      i_ram_rdata,
  input  logic                       i_calc_end,
  output logic                       o_data_loaded
);
  localparam int unsigned SIZE_LOG = $clog2(DATA_WIDTH / 8);
  localparam int unsigned RAM_AW   = $clog2(DEPTH);
  localparam int unsigned IW       = RAM_AW + 1;
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RISSUE, RLOAD, RDATA} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [7:0]              len_q, len_d, beat_q, beat_d;
  logic [1:0]              burst_q, burst_d, resp_q, resp_d;
  logic [IW-1:0]           start_q, start_d;
  logic                    illegal_q, illegal_d, extra_q, extra_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    idle, aw_hs, ar_hs, w_hs, req_bad;
  logic [IW-1:0]           idx, sum, len_x;
  logic                    idx_oor, beat_ok;

  function automatic logic req_illegal(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
    return (size != 3'(SIZE_LOG)) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // READY outputs are gated by reset so they read 0 while i_rstn is low.
  assign idle      = (state_q == IDLE) && i_rstn;
  assign o_AWREADY = idle;
  assign o_ARREADY = idle && !i_AWVALID && ((READ_GATE == 0) || i_calc_end);
  assign aw_hs     = idle && i_AWVALID;
  assign ar_hs     = o_ARREADY && i_ARVALID;
  assign o_WREADY  = (state_q == WDATA);
  assign w_hs      = o_WREADY && i_WVALID;

  always_comb begin
    sum   = start_q + IW'(beat_q);
    len_x = IW'(len_q);
    case (burst_q)
      2'b00:   idx = start_q;
      2'b10:   idx = (start_q & ~len_x) | (sum & len_x);
      default: idx = sum;
    endcase
  end

  assign idx_oor = (idx >= IW'(DEPTH));
  assign beat_ok = !illegal_q && !idx_oor;
  assign req_bad = aw_hs ? req_illegal(i_AWSIZE, i_AWBURST, i_AWLEN)
                         : req_illegal(i_ARSIZE, i_ARBURST, i_ARLEN);

  assign o_ram_we      = w_hs && beat_ok && !extra_q;
  assign o_ram_re      = (state_q == RISSUE) && beat_ok;
  assign o_ram_index   = (state_q == WDATA || state_q == RISSUE) ? idx[RAM_AW-1:0] : '0;
  assign o_ram_wdata   = o_WREADY ? i_WDATA : '0;
  assign o_ram_be      = o_WREADY ? i_WSTRB : '0;
  assign o_BVALID      = (state_q == WRESP);
  assign o_BID         = o_BVALID ? id_q : '0;
  assign o_BRESP       = o_BVALID ? resp_q : OKAY;
  assign o_data_loaded = o_BVALID && i_BREADY && (resp_q == OKAY);
  assign o_RVALID      = (state_q == RDATA);
  assign o_RID         = o_RVALID ? id_q : '0;
  assign o_RRESP       = o_RVALID ? (resp_q | (idx_oor ? SLVERR : OKAY)) : OKAY;
  assign o_RLAST       = o_RVALID && (beat_q == len_q);
  assign o_RDATA       = rdata_q;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    start_d   = start_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    illegal_d = illegal_q;
    extra_d   = extra_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (aw_hs || ar_hs) begin
          id_d      = aw_hs ? i_AWID : i_ARID;
          len_d     = aw_hs ? i_AWLEN : i_ARLEN;
          burst_d   = aw_hs ? i_AWBURST : i_ARBURST;
          start_d   = aw_hs ? IW'(i_AWADDR >> SIZE_LOG) : IW'(i_ARADDR >> SIZE_LOG);
          beat_d    = '0;
          extra_d   = 1'b0;
          illegal_d = req_bad;
          resp_d    = req_bad ? SLVERR : OKAY;
          state_d   = aw_hs ? WDATA : RISSUE;
        end
      end
      WDATA: begin
        if (w_hs) begin
          if (!extra_q) beat_d = beat_q + 8'd1;
          if (!extra_q && idx_oor) resp_d = SLVERR;
          if (i_WLAST) begin
            if (extra_q || beat_q != len_q) resp_d = SLVERR;
            state_d = WRESP;
          end else if (beat_q == len_q) begin
            // Missing WLAST on beat LEN: later beats are beyond the burst and dropped.
            extra_d = 1'b1;
            resp_d  = SLVERR;
          end
        end
      end
      WRESP:  if (i_BREADY) state_d = IDLE;
      RISSUE: state_d = RLOAD;
      RLOAD: begin
        rdata_d = beat_ok ? i_ram_rdata : '0;
        state_d = RDATA;
      end
      RDATA: begin
        if (i_RREADY) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            state_d = RISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      start_q   <= '0;
      beat_q    <= '0;
      resp_q    <= OKAY;
      illegal_q <= 1'b0;
      extra_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      start_q   <= start_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      illegal_q <= illegal_d;
      extra_q   <= extra_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule
